serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder built around the single-bit full-adder cell: it loads two WIDTH-bit operands and a carry-in, then adds one bit per clock, LSB first. The carry is held in a register between bits. It sits in the arithmetic datapath of the lab processor as a low-area alternative to the parallel ripple adder, with a start/busy/done handshake toward the controller. Its combinational core is one full-adder slice: s = a^b^c, co = a&b | (a|b)&c.

## Interface
- WIDTH, 8, operand and sum width in bits (>= 1).

- clk  input  1  rising-edge clock.
- nrst  input  1  synchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on the accepted start edge.
- b  input  WIDTH  operand B, captured on the accepted start edge.
- ci  input  1  carry-in, captured on the accepted start edge.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse: sum/co newly valid.
- sum  output  WIDTH  registered result, held until the next result is written.
- co  output  1  registered carry-out of the MSB slice.

## Operation
- One clock; reset is synchronous and active-low.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - opA <= a, opB <= b, carry <= ci, acc <= 0, cnt <= 0.
  - Go to SHIFT.
- IDLE, start=0: stay in IDLE.
- SHIFT, every edge:
  - bit = opA[0]^opB[0]^carry.
  - carry <= opA[0]&opB[0] | (opA[0]|opB[0])&carry.
  - acc <= {bit, acc[WIDTH-1:1]}.
  - opA and opB shift right by 1.
  - cnt <= cnt+1.
- SHIFT exit: on the edge where cnt == WIDTH-1, go to DONE. On that same edge, load sum with the final shifted acc (including this bit) and load co with the new carry.
- DONE: done=1 for exactly one cycle. Unconditionally go to IDLE.
- start is ignored in SHIFT and DONE. Nothing is queued. The earliest a new start is accepted is the first IDLE cycle.
- cnt is ceil(log2(WIDTH+1)) bits wide. There is no wrap-around; it resets on each accepted start.
- sum and co change only on the SHIFT→DONE edge. They hold their value through IDLE and through the next operation, until its completion.
- Arithmetic: {co, sum} = a + b + ci, modulo 2^(WIDTH+1). Exact, no overflow loss.

## Timing
- Reset (nrst=0 at a rising edge): state=IDLE, busy=0, done=0, sum=0, co=0. Internal registers are cleared.
- Reset mid-operation aborts. done does not pulse and sum/co are zeroed. nrst has priority over start.
- Latency:
  - start accepted at edge E0.
  - Shift edges are E1..EWIDTH.
  - done is high during the cycle after EWIDTH, i.e. WIDTH+1 cycles after E0.
  - Back in IDLE after E(WIDTH+1).
- Throughput: one addition per WIDTH+2 cycles with back-to-back starts.
- busy rises in the cycle after E0 and falls in the cycle after E(WIDTH+1).
- All outputs are registered. There is no combinational path from any input to any output.
- WIDTH=1: one SHIFT cycle, done two cycles after E0.

## Test plan
- Reset: hold nrst=0 for 2 cycles with start=1 -> busy=0, done=0, sum=8'h00, co=0, and no operation starts.
- Basic carry chain: a=8'hFF, b=8'h01, ci=0, start pulse -> done exactly 9 cycles after the start edge, sum=8'h00, co=1, busy high for 9 cycles.
- Carry-in: a=8'h3C, b=8'h5A, ci=1 -> sum=8'h97, co=0. sum keeps 8'h97 until the next completion.
- Start while busy: start at E0 with a=8'h01, b=8'h01, ci=0, then start again at E3 with a=8'hF0, b=8'h0F, ci=1 -> the second start is ignored, one done pulse, sum=8'h02, co=0.
- Reset mid-operation: start with a=8'hAA, b=8'h55, deassert nrst at E4 -> no done pulse, sum=8'h00, state IDLE. A new start after reset with a=8'hAA, b=8'h55, ci=1 -> sum=8'h00, co=1.
- Back-to-back plus random: hold start=1 continuously -> done every 10 cycles. 200 random (a, b, ci) triples give {co, sum} == a+b+ci; repeat with WIDTH=1 and WIDTH=16.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: loads two WIDTH-bit operands and a carry-in, then adds one
// bit per clock LSB first through a single full-adder slice. The carry is held
// in a register between bits. Start/busy/done handshake toward the controller.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  // cnt counts 0..WIDTH-1; sized to hold WIDTH so the width formula stays simple
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] acc_shift;

  // Full-adder slice on the operand LSBs and the accumulator with the new bit
  // entering at the MSB (written without a slice so WIDTH=1 stays legal).
  always_comb begin
    fa_s                 = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    fa_co                = (op_a_q[0] & op_b_q[0]) | ((op_a_q[0] | op_b_q[0]) & carry_q);
    acc_shift            = acc_q >> 1;
    acc_shift[WIDTH-1]   = fa_s;
  end

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      co      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            op_a_q  <= a;
            op_b_q  <= b;
            carry_q <= ci;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          carry_q <= fa_co;
          acc_q   <= acc_shift;
          op_a_q  <= op_a_q >> 1;
          op_b_q  <= op_b_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            // Final bit: publish the result including this slice's output
            sum     <= acc_shift;
            co      <= fa_co;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three instances (WIDTH 8, 1, 16) share
// clock and reset; expected sums go into a scoreboard queue at start time and
// are popped when done pulses.
module tb_serial_adder;

  logic clk;
  logic nrst;

  logic        start8, ci8, busy8, done8, co8;
  logic [7:0]  a8, b8, sum8;
  logic        start1, ci1, busy1, done1, co1;
  logic [0:0]  a1, b1, sum1;
  logic        start16, ci16, busy16, done16, co16;
  logic [15:0] a16, b16, sum16;

  int vectors;
  int miscompares;
  logic [16:0] sb[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .nrst(nrst), .start(start8), .a(a8), .b(b8), .ci(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .co(co8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .nrst(nrst), .start(start1), .a(a1), .b(b1), .ci(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .co(co1)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .nrst(nrst), .start(start16), .a(a16), .b(b16), .ci(ci16),
    .busy(busy16), .done(done16), .sum(sum16), .co(co16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {co, sum} = a + b + ci over w-bit operands
  function automatic logic [16:0] model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                        input logic civ);
    logic [16:0] m;
    m = (17'd1 << w) - 17'd1;
    return ({1'b0, av} & m) + ({1'b0, bv} & m) + {16'd0, civ};
  endfunction

  task automatic apply(input int w, input logic [15:0] av, input logic [15:0] bv,
                       input logic civ, input logic st);
    case (w)
      1: begin a1 = av[0:0]; b1 = bv[0:0]; ci1 = civ; start1 = st; end
      8: begin a8 = av[7:0]; b8 = bv[7:0]; ci8 = civ; start8 = st; end
      default: begin a16 = av; b16 = bv; ci16 = civ; start16 = st; end
    endcase
  endtask

  task automatic set_start(input int w, input logic st);
    case (w)
      1: start1 = st;
      8: start8 = st;
      default: start16 = st;
    endcase
  endtask

  function automatic logic get_done(input int w);
    case (w)
      1: return done1;
      8: return done8;
      default: return done16;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      1: return busy1;
      8: return busy8;
      default: return busy16;
    endcase
  endfunction

  function automatic logic [16:0] get_res(input int w);
    case (w)
      1: return {15'd0, co1, sum1};
      8: return {8'd0, co8, sum8};
      default: return {co16, sum16};
    endcase
  endfunction

  // Single operation with latency, busy-length and result checks
  task automatic run_one(input int w, input logic [15:0] av, input logic [15:0] bv,
                         input logic civ);
    int k;
    int busy_cnt;
    logic [16:0] exp_v;
    @(negedge clk);
    apply(w, av, bv, civ, 1'b1);
    sb.push_back(model(w, av, bv, civ));
    @(negedge clk);
    set_start(w, 1'b0);
    k = 0;
    busy_cnt = 0;
    while (!get_done(w) && k < w + 10) begin
      if (get_busy(w)) busy_cnt++;
      @(negedge clk);
      k++;
    end
    if (get_busy(w)) busy_cnt++;
    vectors++;
    if (!get_done(w)) begin
      miscompares++;
      $display("FAIL done_timeout w=%0d: no done within %0d cycles", w, k);
      void'(sb.pop_front());
    end else begin
      if (k + 1 !== w + 1) begin
        miscompares++;
        $display("FAIL latency w=%0d: got %0d cycles, want %0d", w, k + 1, w + 1);
      end
      vectors++;
      if (busy_cnt !== w + 1) begin
        miscompares++;
        $display("FAIL busy_len w=%0d: got %0d cycles, want %0d", w, busy_cnt, w + 1);
      end
      vectors++;
      exp_v = sb.pop_front();
      if (get_res(w) !== exp_v) begin
        miscompares++;
        $display("FAIL result w=%0d a=%h b=%h ci=%b: got %h, want %h", w, av, bv, civ,
                 get_res(w), exp_v);
      end
    end
    @(negedge clk);
    vectors++;
    if (get_done(w) !== 1'b0 || get_busy(w) !== 1'b0) begin
      miscompares++;
      $display("FAIL post_done w=%0d: done=%b busy=%b, want 0 0", w, get_done(w), get_busy(w));
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    nrst = 1'b0;
    apply(8, 16'h00FF, 16'h0001, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy8, done8, co8, sum8} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b co=%b sum=%h, want all 0", busy8, done8, co8,
               sum8);
    end
    vectors++;
    if ({busy16, done16, co16, sum16, busy1, done1, co1, sum1} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_other: w16 sum=%h co=%b w1 sum=%b co=%b, want 0", sum16, co16, sum1,
               co1);
    end
    start8 = 1'b0;
    nrst = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_start: busy=%b, want 0", busy8);
    end
  endtask

  task automatic test_carry_chain();
    run_one(8, 16'h00FF, 16'h0001, 1'b0);
  endtask

  task automatic test_carry_in();
    run_one(8, 16'h003C, 16'h005A, 1'b1);
    repeat (5) @(negedge clk);
    vectors++;
    if ({co8, sum8} !== 9'h097) begin
      miscompares++;
      $display("FAIL sum_hold_idle: got %h, want 097", {co8, sum8});
    end
  endtask

  task automatic test_start_while_busy();
    int pulses;
    int hold_bad;
    logic [16:0] got;
    logic [16:0] exp_v;
    @(negedge clk);
    apply(8, 16'h0001, 16'h0001, 1'b0, 1'b1);
    sb.push_back(model(8, 16'h0001, 16'h0001, 1'b0));
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    apply(8, 16'h00F0, 16'h000F, 1'b1, 1'b1);
    @(negedge clk);
    start8 = 1'b0;
    pulses = 0;
    hold_bad = 0;
    got = 'x;
    for (int i = 0; i < 30; i++) begin
      if (done8) begin
        pulses++;
        if (pulses == 1) got = {8'd0, co8, sum8};
      end else if (pulses == 0 && sum8 !== 8'h97) begin
        hold_bad++;
      end
      @(negedge clk);
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL busy_start_pulses: got %0d done pulses, want 1", pulses);
    end
    vectors++;
    if (hold_bad !== 0) begin
      miscompares++;
      $display("FAIL sum_hold_busy: %0d cycles with sum != 97, want 0", hold_bad);
    end
    vectors++;
    exp_v = sb.pop_front();
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL busy_start_result: got %h, want %h", got, exp_v);
    end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    @(negedge clk);
    apply(8, 16'h00AA, 16'h0055, 1'b0, 1'b1);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    vectors++;
    if ({busy8, done8, co8, sum8} !== 11'd0) begin
      miscompares++;
      $display("FAIL mid_reset_state: busy=%b done=%b co=%b sum=%h, want all 0", busy8, done8,
               co8, sum8);
    end
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8 || busy8) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL mid_reset_abort: %0d cycles with done/busy, want 0", pulses);
    end
    run_one(8, 16'h00AA, 16'h0055, 1'b1);
  endtask

  // start held high: new operands presented as each done is seen
  task automatic test_back_to_back(input int w, input int n);
    int cyc;
    int last;
    int got_n;
    logic [15:0] av;
    logic [15:0] bv;
    logic civ;
    logic [16:0] exp_v;
    @(negedge clk);
    av = 16'($urandom());
    bv = 16'($urandom());
    civ = 1'($urandom());
    apply(w, av, bv, civ, 1'b1);
    sb.push_back(model(w, av, bv, civ));
    cyc = 0;
    last = -1;
    got_n = 0;
    while (got_n < n && cyc < n * (w + 2) + 20) begin
      @(negedge clk);
      cyc++;
      if (get_done(w)) begin
        vectors++;
        exp_v = sb.pop_front();
        if (get_res(w) !== exp_v) begin
          miscompares++;
          $display("FAIL b2b_result w=%0d: got %h, want %h", w, get_res(w), exp_v);
        end
        if (last >= 0) begin
          vectors++;
          if (cyc - last !== w + 2) begin
            miscompares++;
            $display("FAIL b2b_period w=%0d: got %0d cycles, want %0d", w, cyc - last, w + 2);
          end
        end
        last = cyc;
        got_n++;
        if (got_n < n) begin
          av = 16'($urandom());
          bv = 16'($urandom());
          civ = 1'($urandom());
          apply(w, av, bv, civ, 1'b1);
          sb.push_back(model(w, av, bv, civ));
        end else begin
          set_start(w, 1'b0);
        end
      end
    end
    set_start(w, 1'b0);
    vectors++;
    if (got_n !== n) begin
      miscompares++;
      $display("FAIL b2b_count w=%0d: got %0d results, want %0d", w, got_n, n);
    end
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    nrst = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;
    test_reset();
    test_carry_chain();
    test_carry_in();
    test_start_while_busy();
    test_reset_mid_op();
    run_one(1, 16'h0001, 16'h0001, 1'b1);
    run_one(16, 16'hFFFF, 16'hFFFF, 1'b1);
    test_back_to_back(8, 200);
    test_back_to_back(1, 200);
    test_back_to_back(16, 200);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
